// File: rtl/boot_axi_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : boot_axi_loader_pkg
// Description : Shared AXI encodings and FSM state encoding for the boot
//               image loader.
// Revision    : 1.0  initial release
// ============================================================================
package boot_axi_loader_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;  // bufferable + modifiable

    // Image bursts (AW/W/B), then the single-beat control write (CAW/CW/CB).
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_AW   = 4'd1,
        ST_W    = 4'd2,
        ST_B    = 4'd3,
        ST_CAW  = 4'd4,
        ST_CW   = 4'd5,
        ST_CB   = 4'd6,
        ST_DONE = 4'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/boot_axi_loader_reg_re.sv
`default_nettype none
// ============================================================================
// Module      : boot_axi_loader_reg_re
// Description : Register with synchronous active-high reset (to zero) and
//               load enable.
// Ports       : clk, rst      clock / synchronous reset
//               i_en          load enable
//               i_data        next value
//               o_data        registered value
// Revision    : 1.0  initial release
// ============================================================================
module boot_axi_loader_reg_re #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_data <= '0;
        end else if (i_en) begin
            o_data <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/boot_axi_loader.sv
`default_nettype none
// ============================================================================
// Module      : boot_axi_loader
// Description : AXI4 write initiator that copies a boot image from a
//               valid/ready word stream into memory as INCR bursts, then
//               writes the boot control register to clear boot and request a
//               CPU reset.
// Ports       : clk_i, rst_i            clock / synchronous reset
//               start_i, base_addr_i,
//               nwords_i                job request (sampled when idle)
//               data_i, valid_i, ready_o image word stream
//               busy_o, done_o, error_o  job status
//               axi_aw*/axi_w*/axi_b*    AXI4 write channels (master side)
// Revision    : 1.0  initial release
// ============================================================================
module boot_axi_loader
    import boot_axi_loader_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ID     = 0,
    parameter int BURST_LEN  = 16,
    parameter int CNT_W      = 16,
    parameter int B_BIT      = 15,
    parameter int CTRL_WDATA = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    input  logic [CNT_W-1:0]      nwords_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [AXI_ID_W-1:0]   axi_awid_o,
    output logic [ADDR_W-1:0]     axi_awaddr_o,
    output logic [7:0]            axi_awlen_o,
    output logic [2:0]            axi_awsize_o,
    output logic [1:0]            axi_awburst_o,
    output logic                  axi_awlock_o,
    output logic [3:0]            axi_awcache_o,
    output logic [2:0]            axi_awprot_o,
    output logic [3:0]            axi_awqos_o,
    output logic                  axi_awvalid_o,
    input  logic                  axi_awready_i,
    output logic [DATA_W-1:0]     axi_wdata_o,
    output logic [DATA_W/8-1:0]   axi_wstrb_o,
    output logic                  axi_wlast_o,
    output logic                  axi_wvalid_o,
    input  logic                  axi_wready_i,
    input  logic [AXI_ID_W-1:0]   axi_bid_i,
    input  logic [1:0]            axi_bresp_i,
    input  logic                  axi_bvalid_i,
    output logic                  axi_bready_o
);

    localparam int                c_BEAT_BYTES  = DATA_W / 8;
    localparam int                c_SIZE        = $clog2(c_BEAT_BYTES);
    localparam int                c_BURST_BYTES = BURST_LEN * c_BEAT_BYTES;
    localparam logic [CNT_W-1:0]  c_BURST_LEN   = CNT_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK  = ADDR_W'(c_BURST_BYTES - 1);
    localparam logic [ADDR_W-1:0] c_CTRL_BIT    = ADDR_W'(1) << B_BIT;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [ADDR_W-1:0]   w_cur_addr_d;
    logic [CNT_W-1:0]    r_remaining;
    logic [CNT_W-1:0]    w_remaining_d;
    logic [7:0]          r_beat;
    logic [7:0]          w_beat_d;
    logic                r_error;
    logic                w_error_d;
    logic                w_error_en;
    logic                w_start_acc;
    logic                w_burst_done;
    logic                w_beat_hs;
    logic                w_resp_hs;
    logic [CNT_W-1:0]    w_burst_len;
    logic [7:0]          w_burst_awlen;
    logic [ADDR_W-1:0]   w_burst_bytes;
    logic                w_last_beat;
    logic                w_misaligned;
    logic                w_bad_resp;
    logic                w_unused;

    // Burst length follows the remaining count; it only changes in B, so it
    // stays stable across the AW and W phases of the burst it describes.
    assign w_burst_len   = (r_remaining > c_BURST_LEN) ? c_BURST_LEN : r_remaining;
    assign w_burst_awlen = 8'(w_burst_len - CNT_W'(1));
    assign w_burst_bytes = ADDR_W'(w_burst_len) << c_SIZE;
    assign w_last_beat   = (r_beat == w_burst_awlen);
    assign w_misaligned  = |(base_addr_i & c_ALIGN_MASK);
    assign w_bad_resp    = (axi_bresp_i != AXI_RESP_OKAY);
    assign w_unused      = ^axi_bid_i;

    assign axi_awid_o    = AXI_ID_W'(AXI_ID);
    assign axi_awsize_o  = 3'(c_SIZE);
    assign axi_awburst_o = AXI_BURST_INCR;
    assign axi_awlock_o  = 1'b0;
    assign axi_awcache_o = AXI_CACHE_DEF;
    assign axi_awprot_o  = 3'b000;
    assign axi_awqos_o   = 4'b0000;
    assign axi_wstrb_o   = '1;

    assign busy_o  = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign error_o = r_error;

    // Register next values
    assign w_cur_addr_d  = w_start_acc ? base_addr_i : (r_cur_addr + w_burst_bytes);
    assign w_remaining_d = w_start_acc ? nwords_i : (r_remaining - w_burst_len);
    assign w_beat_d      = w_last_beat ? 8'd0 : (r_beat + 8'd1);
    assign w_error_en    = w_start_acc | (w_resp_hs & w_bad_resp);
    assign w_error_d     = w_start_acc ? w_misaligned : 1'b1;

    boot_axi_loader_reg_re #(.DATA_W(ADDR_W)) u_base_reg (
        .clk(clk_i), .rst(rst_i), .i_en(w_start_acc),
        .i_data(base_addr_i), .o_data(r_base)
    );

    boot_axi_loader_reg_re #(.DATA_W(ADDR_W)) u_addr_reg (
        .clk(clk_i), .rst(rst_i), .i_en(w_start_acc | w_burst_done),
        .i_data(w_cur_addr_d), .o_data(r_cur_addr)
    );

    boot_axi_loader_reg_re #(.DATA_W(CNT_W)) u_remaining_reg (
        .clk(clk_i), .rst(rst_i), .i_en(w_start_acc | w_burst_done),
        .i_data(w_remaining_d), .o_data(r_remaining)
    );

    boot_axi_loader_reg_re #(.DATA_W(8)) u_beat_reg (
        .clk(clk_i), .rst(rst_i), .i_en(w_beat_hs),
        .i_data(w_beat_d), .o_data(r_beat)
    );

    boot_axi_loader_reg_re #(.DATA_W(1)) u_error_reg (
        .clk(clk_i), .rst(rst_i), .i_en(w_error_en),
        .i_data(w_error_d), .o_data(r_error)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start_acc   = 1'b0;
        w_burst_done  = 1'b0;
        w_beat_hs     = 1'b0;
        w_resp_hs     = 1'b0;
        axi_awvalid_o = 1'b0;
        axi_awaddr_o  = r_cur_addr;
        axi_awlen_o   = 8'd0;
        axi_wvalid_o  = 1'b0;
        axi_wdata_o   = '0;
        axi_wlast_o   = 1'b0;
        axi_bready_o  = 1'b0;
        ready_o       = 1'b0;
        done_o        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_start_acc = 1'b1;
                    if (w_misaligned) begin
                        w_state_nxt = ST_DONE;
                    end else if (nwords_i == '0) begin
                        w_state_nxt = ST_CAW;
                    end else begin
                        w_state_nxt = ST_AW;
                    end
                end
            end
            ST_AW: begin
                axi_awvalid_o = 1'b1;
                axi_awlen_o   = w_burst_awlen;
                if (axi_awready_i) begin
                    w_state_nxt = ST_W;
                end
            end
            ST_W: begin
                // Stream is passed straight through to the W channel.
                axi_wvalid_o = valid_i;
                axi_wdata_o  = data_i;
                axi_wlast_o  = w_last_beat;
                ready_o      = axi_wready_i;
                w_beat_hs    = valid_i & axi_wready_i;
                if (w_beat_hs && w_last_beat) begin
                    w_state_nxt = ST_B;
                end
            end
            ST_B: begin
                axi_bready_o = 1'b1;
                if (axi_bvalid_i) begin
                    w_resp_hs    = 1'b1;
                    w_burst_done = 1'b1;
                    if (r_remaining > w_burst_len) begin
                        w_state_nxt = ST_AW;
                    end else if (r_error || w_bad_resp) begin
                        // A failed image is never handed to the CPU.
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_CAW;
                    end
                end
            end
            ST_CAW: begin
                axi_awvalid_o = 1'b1;
                axi_awaddr_o  = r_base | c_CTRL_BIT;
                if (axi_awready_i) begin
                    w_state_nxt = ST_CW;
                end
            end
            ST_CW: begin
                axi_wvalid_o = 1'b1;
                axi_wdata_o  = DATA_W'(CTRL_WDATA);
                axi_wlast_o  = 1'b1;
                if (axi_wready_i) begin
                    w_state_nxt = ST_CB;
                end
            end
            ST_CB: begin
                axi_bready_o = 1'b1;
                if (axi_bvalid_i) begin
                    w_resp_hs   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
